// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-wide memory with byte-lane writes,
// optional wait states and a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          dp_valid_reg, dp_valid_next;
  logic          dp_write_reg;
  logic [AW-1:0] dp_idx_reg;
  logic [3:0]    dp_be_reg;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   rd_raw_reg;
  logic [31:0]   fwd_data_reg;
  logic [3:0]    fwd_be_reg;
  logic [31:0]   rd_merged;

  logic          ready_int;
  logic          accept;
  logic          addr_err;
  logic          wr_commit;
  logic [AW-1:0] acc_idx;
  logic [3:0]    acc_be;
  logic          unused_bits;

  assign ready_int = (state_reg != ST_ERR1) && !((state_reg == ST_WAIT) && (cnt_reg != 4'd0));
  assign hreadyout = ready_int;
  assign hresp     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

  // A new address phase is only sampled on the cycle our own data phase completes.
  assign accept    = hsel && hready && htrans[1] && ready_int;
  assign addr_err  = (haddr >= ADDR_LIMIT) || (hsize > 3'b010) ||
                     ((hsize == 3'b001) && haddr[0]) ||
                     ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  assign acc_idx   = haddr[AW+1:2];
  assign wr_commit = dp_valid_reg && dp_write_reg && ready_int;

  assign unused_bits = ^{hburst, htrans[0]};

  always_comb begin
    acc_be = 4'b0000;
    case (hsize)
      3'b000:  acc_be = 4'b0001 << haddr[1:0];
      3'b001:  acc_be = haddr[1] ? 4'b1100 : 4'b0011;
      default: acc_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dp_valid_next = dp_valid_reg;
    case (state_reg)
      ST_WAIT: if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
      ST_ERR1: state_next = ST_ERR2;
      default: ;
    endcase
    if (ready_int) begin
      state_next    = ST_IDLE;
      cnt_next      = 4'd0;
      dp_valid_next = accept && !addr_err;
      if (accept) begin
        if (addr_err) begin
          state_next = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_next = ST_WAIT;
          cnt_next   = WAIT_LOAD;
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_idx_reg   <= '0;
      dp_be_reg    <= 4'b0000;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dp_valid_reg <= dp_valid_next;
      if (accept) begin
        dp_write_reg <= hwrite;
        dp_idx_reg   <= acc_idx;
        dp_be_reg    <= acc_be;
      end
    end
  end

  // Registered read; a write finishing on the same edge to the same word is
  // captured alongside and merged so back-to-back write/read sees new data.
  always_ff @(posedge hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_commit && dp_be_reg[b]) mem[dp_idx_reg][b*8 +: 8] <= hwdata[b*8 +: 8];
    end
    if (accept) begin
      rd_raw_reg   <= mem[acc_idx];
      fwd_be_reg   <= (wr_commit && (dp_idx_reg == acc_idx)) ? dp_be_reg : 4'b0000;
      fwd_data_reg <= hwdata;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_merged[gi*8 +: 8] = fwd_be_reg[gi] ? fwd_data_reg[gi*8 +: 8] : rd_raw_reg[gi*8 +: 8];
  end

  assign hrdata = (dp_valid_reg && !dp_write_reg) ? rd_merged : 32'h0;

endmodule
